// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Detects load-use and branch-operand hazards in ID and freezes the pipe
// while a data-memory access is outstanding. It also flags a memory access
// that hangs, and keeps saturating activity counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_is_jump,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_mem_read,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // wait_cnt can reach TIMEOUT on the edge that enters HUNG, so size for it.
    localparam int              WC_W    = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HUNG  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [WC_W-1:0] wait_cnt;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic load_use, br_ex, br_mem, hazard, freeze, redirect;

    // Register r0 never creates a dependency, and a source only counts if it is read.
    assign rs_ex  = id_uses_rs && (id_rs != 5'd0) && (id_rs == ex_rd);
    assign rt_ex  = id_uses_rt && (id_rt != 5'd0) && (id_rt == ex_rd);
    assign rs_mem = id_uses_rs && (id_rs != 5'd0) && (id_rs == mem_rd);
    assign rt_mem = id_uses_rt && (id_rt != 5'd0) && (id_rt == mem_rd);

    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs_ex || rt_ex);
    assign br_ex    = id_is_branch && ex_reg_write && (ex_rd != 5'd0) && (rs_ex || rt_ex);
    assign br_mem   = id_is_branch && mem_mem_read && (mem_rd != 5'd0) && (rs_mem || rt_mem);
    assign hazard   = load_use || br_ex || br_mem;
    assign freeze   = dmem_req && !dmem_ready;
    // A branch outcome is only trusted once no hazard is pending; priority handles that.
    assign redirect = id_is_jump || (id_is_branch && id_branch_taken);

    // Priority-ordered control decode: reset, freeze, hazard, redirect.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            // all controls quiet
        end else if (freeze) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            pipe_freeze = 1'b1;
        end else if (hazard) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end else if (redirect) begin
            ifid_flush  = 1'b1;
        end
    end

    // Memory-wait FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= next_state;
    end

    // Memory-wait FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (freeze) next_state = DWAIT;
            DWAIT: begin
                if (!freeze)                  next_state = RUN;
                else if (wait_cnt == WC_LAST) next_state = HUNG;
            end
            HUNG:    if (!freeze) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Consecutive-freeze counter; holds its value once the access is declared hung.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN:     wait_cnt <= freeze ? WC_W'(1) : '0;
                DWAIT:   wait_cnt <= freeze ? wait_cnt + WC_W'(1) : '0;
                HUNG:    wait_cnt <= wait_cnt;
                default: wait_cnt <= '0;
            endcase
        end
    end

    // Sticky hung-memory flag; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset)                                   mem_timeout <= 1'b0;
        else if (state == DWAIT && next_state == HUNG) mem_timeout <= 1'b1;
    end

    // Saturating activity counters, one step per cycle of the matching priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles  <= '0;
            freeze_cycles <= '0;
            flush_count   <= '0;
        end else begin
            if (idex_bubble && stall_cycles != CNT_MAX)  stall_cycles  <= stall_cycles + 1'b1;
            if (pipe_freeze && freeze_cycles != CNT_MAX) freeze_cycles <= freeze_cycles + 1'b1;
            if (ifid_flush && flush_count != CNT_MAX)    flush_count   <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a table of single-cycle control vectors,
// hand sequences for multi-cycle corners, and a random run against a
// rule-level reference model. Two instances share the stimulus: a default
// one and a small one (CNT_W=4, TIMEOUT=4) for timeout and saturation.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       tk;
        logic       jmp;
        logic [4:0] exrd;
        logic       exw;
        logic       exld;
        logic [4:0] memrd;
        logic       memld;
        logic       req;
        logic       rdy;
    } in_t;

    // expected control bits are {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}
    typedef struct {
        string      name;
        in_t        in;
        logic [4:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    in_t  cur   = '0;

    logic        a_pc, a_ifs, a_ifl, a_bub, a_frz, a_to;
    logic [15:0] a_stall, a_freeze, a_flush;
    logic        b_pc, b_ifs, b_ifl, b_bub, b_frz, b_to;
    logic [3:0]  b_stall, b_freeze, b_flush;

    int tests = 0;
    int fails = 0;

    // reference model state
    int m_stall, m_freeze, m_flush, m_run;
    bit m_to_a, m_to_b;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl u_dut (
        .clock(clock), .reset(reset),
        .id_rs(cur.rs), .id_rt(cur.rt), .id_uses_rs(cur.urs), .id_uses_rt(cur.urt),
        .id_is_branch(cur.br), .id_branch_taken(cur.tk), .id_is_jump(cur.jmp),
        .ex_rd(cur.exrd), .ex_reg_write(cur.exw), .ex_mem_read(cur.exld),
        .mem_rd(cur.memrd), .mem_mem_read(cur.memld),
        .dmem_req(cur.req), .dmem_ready(cur.rdy),
        .pc_stall(a_pc), .ifid_stall(a_ifs), .ifid_flush(a_ifl), .idex_bubble(a_bub),
        .pipe_freeze(a_frz), .mem_timeout(a_to),
        .stall_cycles(a_stall), .freeze_cycles(a_freeze), .flush_count(a_flush)
    );

    pipeline_hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) u_small (
        .clock(clock), .reset(reset),
        .id_rs(cur.rs), .id_rt(cur.rt), .id_uses_rs(cur.urs), .id_uses_rt(cur.urt),
        .id_is_branch(cur.br), .id_branch_taken(cur.tk), .id_is_jump(cur.jmp),
        .ex_rd(cur.exrd), .ex_reg_write(cur.exw), .ex_mem_read(cur.exld),
        .mem_rd(cur.memrd), .mem_mem_read(cur.memld),
        .dmem_req(cur.req), .dmem_ready(cur.rdy),
        .pc_stall(b_pc), .ifid_stall(b_ifs), .ifid_flush(b_ifl), .idex_bubble(b_bub),
        .pipe_freeze(b_frz), .mem_timeout(b_to),
        .stall_cycles(b_stall), .freeze_cycles(b_freeze), .flush_count(b_flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit uses(input logic u, input logic [4:0] idx, input logic [4:0] rd);
        return u && idx != 0 && idx == rd;
    endfunction

    // Expected controls from the hazard rules, highest priority first.
    function automatic logic [4:0] ref_ctrl(input in_t v, input logic rst);
        bit dep_ex, dep_mem, haz;
        dep_ex  = uses(v.urs, v.rs, v.exrd)  || uses(v.urt, v.rt, v.exrd);
        dep_mem = uses(v.urs, v.rs, v.memrd) || uses(v.urt, v.rt, v.memrd);
        haz = (v.exrd != 0 && dep_ex && (v.exld || (v.br && v.exw)))
           || (v.br && v.memld && v.memrd != 0 && dep_mem);
        if (rst)                      return 5'b00000;
        if (v.req && !v.rdy)          return 5'b11001;
        if (haz)                      return 5'b11010;
        if (v.jmp || (v.br && v.tk))  return 5'b00100;
        return 5'b00000;
    endfunction

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    // One clock cycle: drive, check controls and state against the model,
    // advance the model across the edge, and return observed controls.
    task automatic cycle(input in_t v, input logic rst, output logic [4:0] obs);
        logic [4:0] e;
        cur = v;
        reset = rst;
        #1;
        e   = ref_ctrl(v, rst);
        obs = {a_pc, a_ifs, a_ifl, a_bub, a_frz};
        chk("ctrl_a", {27'd0, obs}, {27'd0, e});
        chk("ctrl_b", {27'd0, b_pc, b_ifs, b_ifl, b_bub, b_frz}, {27'd0, e});
        chk("stall_a",  {16'd0, a_stall},  sat(m_stall, 65535));
        chk("freeze_a", {16'd0, a_freeze}, sat(m_freeze, 65535));
        chk("flush_a",  {16'd0, a_flush},  sat(m_flush, 65535));
        chk("stall_b",  {28'd0, b_stall},  sat(m_stall, 15));
        chk("freeze_b", {28'd0, b_freeze}, sat(m_freeze, 15));
        chk("flush_b",  {28'd0, b_flush},  sat(m_flush, 15));
        chk("timeout_a", {31'd0, a_to}, {31'd0, m_to_a});
        chk("timeout_b", {31'd0, b_to}, {31'd0, m_to_b});
        if (rst) begin
            m_stall = 0; m_freeze = 0; m_flush = 0; m_run = 0;
            m_to_a = 0; m_to_b = 0;
        end else begin
            m_stall  += e[1];
            m_freeze += e[0];
            m_flush  += e[2];
            m_run = (v.req && !v.rdy) ? m_run + 1 : 0;
            if (m_run == 64) m_to_a = 1;
            if (m_run == 4)  m_to_b = 1;
        end
        @(posedge clock);
        #1;
    endtask

    vec_t tbl[14];
    in_t  z, lu, frz, v;
    logic [4:0] o;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        z   = '0;
        lu  = in_t'{rs: 5'd5, urs: 1'b1, exld: 1'b1, exrd: 5'd5, default: '0};
        frz = in_t'{req: 1'b1, rdy: 1'b0, default: '0};
        tbl[0]  = '{"lu_rs",       lu, 5'b11010};
        tbl[1]  = '{"lu_rd0",      in_t'{rs: 5'd0, urs: 1'b1, exld: 1'b1, exrd: 5'd0, default: '0}, 5'b00000};
        tbl[2]  = '{"lu_rt_unused",in_t'{rt: 5'd6, urt: 1'b0, exld: 1'b1, exrd: 5'd6, default: '0}, 5'b00000};
        tbl[3]  = '{"lu_rt",       in_t'{rt: 5'd6, urt: 1'b1, exld: 1'b1, exrd: 5'd6, default: '0}, 5'b11010};
        tbl[4]  = '{"br_ex",       in_t'{br: 1'b1, rt: 5'd3, urt: 1'b1, exw: 1'b1, exrd: 5'd3, default: '0}, 5'b11010};
        tbl[5]  = '{"br_mem",      in_t'{br: 1'b1, rs: 5'd7, urs: 1'b1, memld: 1'b1, memrd: 5'd7, default: '0}, 5'b11010};
        tbl[6]  = '{"nobr_mem",    in_t'{rs: 5'd7, urs: 1'b1, memld: 1'b1, memrd: 5'd7, default: '0}, 5'b00000};
        tbl[7]  = '{"jump",        in_t'{jmp: 1'b1, default: '0}, 5'b00100};
        tbl[8]  = '{"br_taken",    in_t'{br: 1'b1, tk: 1'b1, default: '0}, 5'b00100};
        tbl[9]  = '{"br_nottaken", in_t'{br: 1'b1, default: '0}, 5'b00000};
        tbl[10] = '{"jump_lu",     in_t'{jmp: 1'b1, rs: 5'd5, urs: 1'b1, exld: 1'b1, exrd: 5'd5, default: '0}, 5'b11010};
        tbl[11] = '{"freeze",      frz, 5'b11001};
        tbl[12] = '{"freeze_over", in_t'{req: 1'b1, jmp: 1'b1, rs: 5'd5, urs: 1'b1, exld: 1'b1, exrd: 5'd5, default: '0}, 5'b11001};
        tbl[13] = '{"req_ready",   in_t'{req: 1'b1, rdy: 1'b1, jmp: 1'b1, default: '0}, 5'b00100};

        @(posedge clock);
        #1;
        // reset with a freeze request present: controls stay quiet
        cycle(frz, 1'b1, o);
        chk("reset_ctrl", {27'd0, o}, 32'd0);
        cycle(z, 1'b1, o);
        chk("reset_timeout", {31'd0, b_to}, 32'd0);
        chk("reset_stall", {16'd0, a_stall}, 32'd0);

        foreach (tbl[i]) begin
            cycle(tbl[i].in, 1'b0, o);
            chk(tbl[i].name, {27'd0, o}, {27'd0, tbl[i].exp});
        end

        // load-use: one stall cycle counted
        cycle(z, 1'b1, o);
        cycle(lu, 1'b0, o);
        chk("lu_seq_ctrl", {27'd0, o}, 32'h1A);
        chk("lu_seq_cnt", {16'd0, a_stall}, 32'd1);

        // branch on a load result: load_use then br_mem, then taken flush
        v = in_t'{br: 1'b1, rt: 5'd3, urt: 1'b1, exld: 1'b1, exw: 1'b1, exrd: 5'd3, default: '0};
        cycle(z, 1'b1, o);
        cycle(v, 1'b0, o);
        chk("chain_s1", {27'd0, o}, 32'h1A);
        v = in_t'{br: 1'b1, rt: 5'd3, urt: 1'b1, memld: 1'b1, memrd: 5'd3, default: '0};
        cycle(v, 1'b0, o);
        chk("chain_s2", {27'd0, o}, 32'h1A);
        v = in_t'{br: 1'b1, tk: 1'b1, rt: 5'd3, urt: 1'b1, default: '0};
        cycle(v, 1'b0, o);
        chk("chain_flush", {27'd0, o}, 32'h04);
        chk("chain_flush_cnt", {16'd0, a_flush}, 32'd1);
        chk("chain_stall_cnt", {16'd0, a_stall}, 32'd2);

        // jump held off by a hazard, then taken
        v = lu;
        v.jmp = 1'b1;
        cycle(v, 1'b0, o);
        chk("jmp_haz", {27'd0, o}, 32'h1A);
        cycle(in_t'{jmp: 1'b1, default: '0}, 1'b0, o);
        chk("jmp_after", {27'd0, o}, 32'h04);

        // six-cycle freeze: default instance must not time out, small one at edge 4
        cycle(z, 1'b1, o);
        for (int k = 1; k <= 6; k++) begin
            cycle(frz, 1'b0, o);
            chk("frz_ctrl", {27'd0, o}, 32'h19);
            chk("frz_timeout_small", {31'd0, b_to}, (k >= 4) ? 32'd1 : 32'd0);
            if (k == 5) chk("frz_cnt5", {16'd0, a_freeze}, 32'd5);
        end
        chk("frz_no_timeout", {31'd0, a_to}, 32'd0);
        cycle(in_t'{req: 1'b1, rdy: 1'b1, default: '0}, 1'b0, o);
        chk("frz_release", {27'd0, o}, 32'd0);
        cycle(z, 1'b0, o);
        chk("timeout_sticky", {31'd0, b_to}, 32'd1);
        cycle(z, 1'b1, o);
        chk("timeout_cleared", {31'd0, b_to}, 32'd0);

        // saturation of the 4-bit counter
        for (int k = 0; k < 20; k++) cycle(lu, 1'b0, o);
        chk("sat_small", {28'd0, b_stall}, 32'd15);
        chk("sat_big", {16'd0, a_stall}, 32'd20);

        // reset in the middle of a hung freeze, then a fresh freeze
        for (int k = 0; k < 5; k++) cycle(frz, 1'b0, o);
        cycle(frz, 1'b1, o);
        chk("midrst_timeout", {31'd0, b_to}, 32'd0);
        chk("midrst_freeze", {16'd0, a_freeze}, 32'd0);
        for (int k = 0; k < 3; k++) cycle(frz, 1'b0, o);
        chk("midrst_fresh", {31'd0, b_to}, 32'd0);

        // random traffic with small register indices to provoke matches
        for (int n = 0; n < 2000; n++) begin
            v = in_t'({$urandom, $urandom});
            v.rs    = v.rs & 5'd3;
            v.rt    = v.rt & 5'd3;
            v.exrd  = v.exrd & 5'd3;
            v.memrd = v.memrd & 5'd3;
            v.rdy   = ($urandom_range(0, 3) != 0);
            cycle(v, ($urandom_range(0, 149) == 0), o);
        end
        cycle(z, 1'b0, o);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
